// File: rtl/usbf_pkg.sv
// ---------------------------------------------------------------------------
// usbf_pkg
//   Shared definitions for the USB function SIE blocks:
//     - full PID byte constants ({~pid, pid}) for data and handshake packets
//     - transmitter state encoding
//     - CRC16 init value and reflected polynomial
//     - helper to classify a PID byte as a data-packet PID
// ---------------------------------------------------------------------------
package usbf_pkg;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  // USB CRC16 (0x8005) in its bit-reflected form, processed LSB first.
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY = 16'hA001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_PID,
    ST_DATA,
    ST_CRC0,
    ST_CRC1
  } tx_state_t;

  // DATA0/DATA1/DATA2/MDATA all share pid[1:0] == 2'b11.
  function automatic logic pid_is_data(input logic [7:0] pid);
    return (pid[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/usbf_crc16.sv
// ---------------------------------------------------------------------------
// usbf_crc16
//   Combinational byte-wise USB CRC16 update (reflected 0xA001, LSB first).
//   Used by the transmitter and intended for the receiver CRC checker.
//
//   crc_i   in  16  running CRC before this byte
//   data_i  in   8  byte to fold in
//   crc_o   out 16  running CRC after this byte (not complemented)
// ---------------------------------------------------------------------------
module usbf_crc16
  import usbf_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  logic [15:0] w_acc;

  // Folding the whole byte into the low bits first and then shifting eight
  // times is equivalent to eight single-bit LFSR steps, LSB first.
  always_comb begin
    w_acc = crc_i ^ {8'h00, data_i};
    for (int i = 0; i < 8; i++) begin
      w_acc = w_acc[0] ? ((w_acc >> 1) ^ CRC16_POLY) : (w_acc >> 1);
    end
    crc_o = w_acc;
  end

endmodule

// File: rtl/usbf_sie_tx.sv
// ---------------------------------------------------------------------------
// usbf_sie_tx
//   USB SIE packet transmitter. On tx_start_i it waits TX_DELAY turnaround
//   cycles, then sends either a handshake packet (PID only) or a data packet
//   (PID, payload pulled from the endpoint stream, complemented CRC16).
//   A payload underrun cannot stall UTMI, so the packet is finished with an
//   inverted CRC to force the host to discard it.
//
//   Parameters
//     TX_DELAY        bus-turnaround cycles before txvalid (0..255)
//   Ports
//     clk_i           clock
//     rstn_i          asynchronous active-low reset
//     tx_start_i      one-cycle send request (sampled only when idle)
//     tx_pid_i[7:0]   full PID byte, captured on start
//     data_valid_i    endpoint stream beat present
//     data_strb_i     beat carries a real byte (low + last = ZLP)
//     data_i[7:0]     endpoint stream byte
//     data_last_i     final beat of the payload
//     data_accept_o   endpoint beat consumed this cycle
//     utmi_data_o     UTMI Tx byte
//     utmi_txvalid_o  UTMI Tx valid
//     utmi_txready_i  UTMI accepted the byte
//     tx_busy_o       packet in progress
//     tx_done_o       one-cycle pulse after the final byte handshake
//     tx_err_o        one-cycle pulse after a payload underrun
// ---------------------------------------------------------------------------
module usbf_sie_tx
  import usbf_pkg::*;
#(
  parameter int TX_DELAY = 4
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       tx_start_i,
  input  logic [7:0] tx_pid_i,
  input  logic       data_valid_i,
  input  logic       data_strb_i,
  input  logic [7:0] data_i,
  input  logic       data_last_i,
  output logic       data_accept_o,
  output logic [7:0] utmi_data_o,
  output logic       utmi_txvalid_o,
  input  logic       utmi_txready_i,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_err_o
);

  localparam logic [7:0] LP_DELAY = 8'(TX_DELAY);

  tx_state_t   r_state;
  tx_state_t   w_state_next;
  logic [7:0]  r_pid;
  logic [7:0]  r_cnt;
  logic [15:0] r_crc;
  logic        r_corrupt;
  logic        r_done;
  logic        r_err;

  logic [15:0] w_crc_upd;
  logic        w_load;
  logic        w_crc_en;
  logic        w_set_corrupt;
  logic        w_done_set;
  logic        w_err_set;
  logic        w_zlp;
  logic        w_underrun;
  logic [15:0] w_crc_tx;

  usbf_crc16 u_crc16 (
    .crc_i  (r_crc),
    .data_i (data_i),
    .crc_o  (w_crc_upd)
  );

  assign w_zlp      = data_valid_i && !data_strb_i;
  assign w_underrun = utmi_txready_i && !data_valid_i;

  // Normal CRC goes out complemented; a corrupted packet sends the raw value,
  // i.e. the inverse of what the host expects.
  assign w_crc_tx = r_corrupt ? r_crc : ~r_crc;

  // NOTE: every signal driven here gets a default before the case statement,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_next   = r_state;
    utmi_data_o    = 8'h00;
    utmi_txvalid_o = 1'b0;
    data_accept_o  = 1'b0;
    w_load         = 1'b0;
    w_crc_en       = 1'b0;
    w_set_corrupt  = 1'b0;
    w_done_set     = 1'b0;
    w_err_set      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (tx_start_i) begin
          w_load       = 1'b1;
          w_state_next = (LP_DELAY == 8'd0) ? ST_PID : ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (r_cnt <= 8'd1) w_state_next = ST_PID;
      end

      ST_PID: begin
        utmi_data_o    = r_pid;
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          if (pid_is_data(r_pid)) begin
            w_state_next = ST_DATA;
          end else begin
            w_state_next = ST_IDLE;
            w_done_set   = 1'b1;
          end
        end
      end

      ST_DATA: begin
        utmi_data_o = data_i;
        if (w_zlp) begin
          // Zero-length marker: consume the beat without offering UTMI a byte.
          data_accept_o = 1'b1;
          w_state_next  = ST_CRC0;
        end else begin
          utmi_txvalid_o = 1'b1;
          if (utmi_txready_i && data_valid_i) begin
            data_accept_o = 1'b1;
            w_crc_en      = 1'b1;
            if (data_last_i) w_state_next = ST_CRC0;
          end else if (w_underrun) begin
            // UTMI took a junk byte; finish with a poisoned CRC.
            w_err_set     = 1'b1;
            w_set_corrupt = 1'b1;
            w_state_next  = ST_CRC0;
          end
        end
      end

      ST_CRC0: begin
        utmi_data_o    = w_crc_tx[7:0];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) w_state_next = ST_CRC1;
      end

      ST_CRC1: begin
        utmi_data_o    = w_crc_tx[15:8];
        utmi_txvalid_o = 1'b1;
        if (utmi_txready_i) begin
          w_state_next = ST_IDLE;
          w_done_set   = 1'b1;
        end
      end

      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= ST_IDLE;
      r_pid     <= 8'h00;
      r_cnt     <= 8'h00;
      r_crc     <= CRC16_INIT;
      r_corrupt <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_set;
      r_err   <= w_err_set;

      if (w_load) begin
        r_pid     <= tx_pid_i;
        r_cnt     <= LP_DELAY;
        r_crc     <= CRC16_INIT;
        r_corrupt <= 1'b0;
      end else begin
        if (r_state == ST_WAIT) r_cnt <= r_cnt - 8'd1;
        if (w_crc_en)           r_crc <= w_crc_upd;
        if (w_set_corrupt)      r_corrupt <= 1'b1;
      end
    end
  end

  assign tx_busy_o = (r_state != ST_IDLE);
  assign tx_done_o = r_done;
  assign tx_err_o  = r_err;

endmodule

// File: tb/tb_usbf_sie_tx.sv
// ---------------------------------------------------------------------------
// tb_usbf_sie_tx
//   Self-checking bench for usbf_sie_tx. Each scenario drives one packet,
//   collects the UTMI byte stream and pulse counts, and compares them against
//   a packet-level reference model (expected byte list, accept/err counts).
//   A second instance with TX_DELAY=0 checks the turnaround bypass.
// ---------------------------------------------------------------------------
module tb_usbf_sie_tx;
  import usbf_pkg::*;

  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic       tx_start_i;
  logic [7:0] tx_pid_i;
  logic       data_valid_i;
  logic       data_strb_i;
  logic [7:0] data_i;
  logic       data_last_i;
  logic       data_accept_o;
  logic [7:0] utmi_data_o;
  logic       utmi_txvalid_o;
  logic       utmi_txready_i;
  logic       tx_busy_o;
  logic       tx_done_o;
  logic       tx_err_o;

  logic       accept_z, txvalid_z, busy_z, done_z, err_z;
  logic [7:0] data_z;

  usbf_sie_tx #(.TX_DELAY(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .tx_start_i(tx_start_i), .tx_pid_i(tx_pid_i),
    .data_valid_i(data_valid_i), .data_strb_i(data_strb_i), .data_i(data_i),
    .data_last_i(data_last_i), .data_accept_o(data_accept_o), .utmi_data_o(utmi_data_o),
    .utmi_txvalid_o(utmi_txvalid_o), .utmi_txready_i(utmi_txready_i),
    .tx_busy_o(tx_busy_o), .tx_done_o(tx_done_o), .tx_err_o(tx_err_o)
  );

  usbf_sie_tx #(.TX_DELAY(0)) dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i), .tx_start_i(tx_start_i), .tx_pid_i(tx_pid_i),
    .data_valid_i(data_valid_i), .data_strb_i(data_strb_i), .data_i(data_i),
    .data_last_i(data_last_i), .data_accept_o(accept_z), .utmi_data_o(data_z),
    .utmi_txvalid_o(txvalid_z), .utmi_txready_i(utmi_txready_i),
    .tx_busy_o(busy_z), .tx_done_o(done_z), .tx_err_o(err_z)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Stimulus payload and observations of the last packet.
  logic [7:0] pay_q[$];
  logic [7:0] obs_q[$];
  int         obs_acc, obs_done, obs_err;
  int         first_valid, first_valid0, busy_cycles, done_off;
  logic       done_busy, done_txvalid;
  bit         stable_ok, timed_out;

  // Reference model outputs.
  logic [7:0] exp_q[$];
  bit         exp_dc[$];
  int         exp_acc, exp_err;

  // CRC16 straight from its definition: one bit at a time, LSB first.
  function automatic logic [15:0] crc_model(input int nbytes);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < nbytes; k++)
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ pay_q[k][j];
        c  = c >> 1;
        if (fb) c = c ^ 16'hA001;
      end
    return c;
  endfunction

  // Expected UTMI bytes for one packet, plus accept/error counts.
  task automatic build_expected(input logic [7:0] pid, input bit zlp, input int underrun_after);
    int          sent;
    logic [15:0] crc;
    exp_q.delete(); exp_dc.delete();
    exp_q.push_back(pid); exp_dc.push_back(0);
    exp_acc = 0; exp_err = 0;
    if (pid[1:0] == 2'b11) begin
      sent = zlp ? 0 : ((underrun_after >= 0) ? underrun_after : pay_q.size());
      for (int k = 0; k < sent; k++) begin
        exp_q.push_back(pay_q[k]); exp_dc.push_back(0);
      end
      crc = crc_model(sent);
      exp_acc = zlp ? 1 : sent;
      if (underrun_after >= 0) begin
        exp_err = 1;
        exp_q.push_back(8'h00); exp_dc.push_back(1);
        exp_q.push_back(crc[7:0]);  exp_dc.push_back(0);
        exp_q.push_back(crc[15:8]); exp_dc.push_back(0);
      end else begin
        exp_q.push_back(~crc[7:0]);  exp_dc.push_back(0);
        exp_q.push_back(~crc[15:8]); exp_dc.push_back(0);
      end
    end
  endtask

  // Drive one packet request, play the endpoint stream from pay_q and record
  // everything the DUT does until two cycles after its done pulse.
  task automatic drive_packet(input logic [7:0] pid, input bit zlp, input int underrun_after,
                              input bit rand_ready, input bit extra_start);
    int         c, idx, post, off;
    bit         zlp_taken, prev_stall;
    logic [7:0] prev_data;
    obs_q.delete();
    obs_acc = 0; obs_done = 0; obs_err = 0;
    first_valid = -1; first_valid0 = -1; busy_cycles = 0; done_off = -1;
    done_busy = 1'b1; done_txvalid = 1'b1; stable_ok = 1; timed_out = 0;
    idx = 0; post = -1; zlp_taken = 0; prev_stall = 0; prev_data = 8'h00;

    @(negedge clk_i);
    tx_start_i = 1'b1; tx_pid_i = pid; c = cyc;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      tx_start_i = extra_start && (i == 3);
      if (zlp) begin
        data_valid_i = !zlp_taken; data_strb_i = 1'b0; data_last_i = 1'b1; data_i = 8'h00;
      end else if (idx < pay_q.size() && (underrun_after < 0 || idx < underrun_after)) begin
        data_valid_i = 1'b1; data_strb_i = 1'b1; data_i = pay_q[idx];
        data_last_i = (idx == pay_q.size() - 1);
      end else begin
        data_valid_i = 1'b0; data_strb_i = 1'b0; data_last_i = 1'b0; data_i = 8'h00;
      end
      utmi_txready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      off = cyc - c;
      if (tx_busy_o) busy_cycles++;
      if (utmi_txvalid_o && first_valid < 0) first_valid = off;
      if (txvalid_z && first_valid0 < 0) first_valid0 = off;
      if (prev_stall && (!utmi_txvalid_o || utmi_data_o !== prev_data)) stable_ok = 0;
      prev_stall = utmi_txvalid_o && !utmi_txready_i;
      prev_data  = utmi_data_o;
      if (utmi_txvalid_o && utmi_txready_i) obs_q.push_back(utmi_data_o);
      if (data_accept_o) begin
        obs_acc++;
        if (zlp) zlp_taken = 1; else idx++;
      end
      if (tx_err_o) obs_err++;
      if (post >= 0) begin
        post++;
        if (post > 2) break;
      end
      if (tx_done_o) begin
        obs_done++;
        if (done_off < 0) begin
          done_off = off; done_busy = tx_busy_o; done_txvalid = utmi_txvalid_o; post = 0;
        end
      end
      if (i == 299) timed_out = 1;
    end
    tx_start_i = 1'b0; data_valid_i = 1'b0; data_strb_i = 1'b0; data_last_i = 1'b0;
    utmi_txready_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0; tx_start_i = 1'b0; tx_pid_i = 8'h00; data_valid_i = 1'b0;
    data_strb_i = 1'b0; data_i = 8'h00; data_last_i = 1'b0; utmi_txready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    n_vec++;
    if ({utmi_txvalid_o, tx_busy_o, tx_done_o, tx_err_o, data_accept_o, utmi_data_o} !== 13'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got txv=%b busy=%b done=%b err=%b acc=%b data=%h, want all 0",
               utmi_txvalid_o, tx_busy_o, tx_done_o, tx_err_o, data_accept_o, utmi_data_o);
    end
    rstn_i = 1'b1;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if ({utmi_txvalid_o, tx_busy_o, tx_done_o, tx_err_o} !== 4'h0) begin
      n_err++;
      $display("FAIL post_reset_idle: got txv=%b busy=%b done=%b err=%b, want 0000",
               utmi_txvalid_o, tx_busy_o, tx_done_o, tx_err_o);
    end
  endtask

  task automatic test_handshake();
    pay_q.delete();
    drive_packet(PID_ACK, 0, -1, 0, 0);
    build_expected(PID_ACK, 0, -1);
    n_vec++;
    if (timed_out) begin n_err++; $display("FAIL hs_timeout: no done pulse within budget"); end
    n_vec++;
    if (obs_q.size() != exp_q.size() || obs_q[0] !== PID_ACK) begin
      n_err++;
      $display("FAIL hs_bytes: got %0d bytes first=%h, want 1 byte d2", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 8'hxx);
    end
    n_vec++;
    if (first_valid != 5) begin n_err++; $display("FAIL hs_txvalid_latency: got %0d, want 5", first_valid); end
    n_vec++;
    if (first_valid0 != 1) begin n_err++; $display("FAIL hs_zero_delay_latency: got %0d, want 1", first_valid0); end
    n_vec++;
    if (busy_cycles != 5) begin n_err++; $display("FAIL hs_busy_cycles: got %0d, want 5", busy_cycles); end
    n_vec++;
    if (done_off != 6) begin n_err++; $display("FAIL hs_done_offset: got %0d, want 6", done_off); end
    n_vec++;
    if (done_busy !== 1'b0 || done_txvalid !== 1'b0) begin
      n_err++; $display("FAIL hs_done_cycle: got busy=%b txv=%b, want 0 0", done_busy, done_txvalid);
    end
    n_vec++;
    if (obs_done != 1 || obs_err != 0 || obs_acc != 0) begin
      n_err++; $display("FAIL hs_pulses: got done=%0d err=%0d acc=%0d, want 1 0 0", obs_done, obs_err, obs_acc);
    end
  endtask

  task automatic test_zlp();
    pay_q.delete();
    drive_packet(PID_DATA1, 1, -1, 0, 0);
    build_expected(PID_DATA1, 1, -1);
    n_vec++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL zlp_len: got %0d bytes timeout=%0d, want %0d", obs_q.size(), timed_out, exp_q.size());
    end else
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL zlp_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
        end
      end
    n_vec++;
    if (obs_acc != 1 || obs_err != 0 || obs_done != 1) begin
      n_err++; $display("FAIL zlp_pulses: got acc=%0d err=%0d done=%0d, want 1 0 1", obs_acc, obs_err, obs_done);
    end
  endtask

  task automatic test_payload4();
    pay_q = '{8'h00, 8'h01, 8'h02, 8'h03};
    drive_packet(PID_DATA0, 0, -1, 1, 0);
    build_expected(PID_DATA0, 0, -1);
    n_vec++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL p4_len: got %0d bytes timeout=%0d, want %0d", obs_q.size(), timed_out, exp_q.size());
    end else
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL p4_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
        end
      end
    n_vec++;
    if (!stable_ok) begin n_err++; $display("FAIL p4_stall_stable: got unstable byte/valid during stall, want stable"); end
    n_vec++;
    if (obs_acc != 4 || obs_err != 0 || obs_done != 1) begin
      n_err++; $display("FAIL p4_pulses: got acc=%0d err=%0d done=%0d, want 4 0 1", obs_acc, obs_err, obs_done);
    end
  endtask

  task automatic test_underrun();
    pay_q.delete();
    repeat (4) pay_q.push_back(8'($urandom));
    drive_packet(PID_DATA1, 0, 2, 0, 0);
    build_expected(PID_DATA1, 0, 2);
    n_vec++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL ur_len: got %0d bytes timeout=%0d, want %0d", obs_q.size(), timed_out, exp_q.size());
    end else
      foreach (exp_q[i])
        if (!exp_dc[i]) begin
          n_vec++;
          if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL ur_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
          end
        end
    n_vec++;
    if (obs_err != exp_err || obs_acc != exp_acc || obs_done != 1) begin
      n_err++; $display("FAIL ur_pulses: got err=%0d acc=%0d done=%0d, want %0d %0d 1",
                        obs_err, obs_acc, obs_done, exp_err, exp_acc);
    end
  endtask

  task automatic test_start_busy();
    pay_q.delete();
    repeat (3) pay_q.push_back(8'($urandom));
    drive_packet(PID_DATA0, 0, -1, 1, 1);
    build_expected(PID_DATA0, 0, -1);
    n_vec++;
    if (timed_out || obs_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL busy_start_len: got %0d bytes timeout=%0d, want %0d", obs_q.size(), timed_out, exp_q.size());
    end else
      foreach (exp_q[i]) begin
        n_vec++;
        if (obs_q[i] !== exp_q[i]) begin
          n_err++; $display("FAIL busy_start_byte%0d: got %h, want %h", i, obs_q[i], exp_q[i]);
        end
      end
    n_vec++;
    if (obs_done != 1) begin n_err++; $display("FAIL busy_start_done: got %0d pulses, want 1", obs_done); end
  endtask

  task automatic test_reset_midpacket();
    bit seen;
    pay_q.delete();
    repeat (8) pay_q.push_back(8'($urandom));
    seen = 0;
    @(negedge clk_i);
    tx_pid_i = PID_DATA0; tx_start_i = 1'b1;
    @(negedge clk_i);
    tx_start_i = 1'b0; data_valid_i = 1'b1; data_strb_i = 1'b1; data_i = pay_q[0];
    data_last_i = 1'b0; utmi_txready_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i); #1;
      if (data_accept_o) begin seen = 1; break; end
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL rst_mid_reach_data: got no accept, want DATA state reached"); end
    #2 rstn_i = 1'b0;
    #1;
    n_vec++;
    if ({utmi_txvalid_o, tx_busy_o, data_accept_o} !== 3'b000) begin
      n_err++; $display("FAIL rst_mid_async: got txv=%b busy=%b acc=%b, want 000",
                        utmi_txvalid_o, tx_busy_o, data_accept_o);
    end
    @(posedge clk_i); #1;
    n_vec++;
    if (tx_done_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_done: got %b, want 0", tx_done_o); end
    @(negedge clk_i);
    rstn_i = 1'b1; data_valid_i = 1'b0; data_strb_i = 1'b0; utmi_txready_i = 1'b0;
    pay_q.delete();
    drive_packet(PID_ACK, 0, -1, 0, 0);
    n_vec++;
    if (timed_out || obs_q.size() != 1 || obs_q[0] !== PID_ACK || obs_done != 1) begin
      n_err++; $display("FAIL rst_mid_recover: got %0d bytes first=%h done=%0d, want 1 byte d2 done 1",
                        obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'hxx, obs_done);
    end
  endtask

  task automatic test_random_packets();
    logic [7:0] pids[5];
    logic [7:0] pid;
    bit         zlp;
    int         n;
    pids = '{PID_DATA0, PID_DATA1, PID_ACK, PID_NAK, PID_STALL};
    for (int p = 0; p < 8; p++) begin
      pid = pids[$urandom_range(0, 4)];
      n   = $urandom_range(1, 8);
      pay_q.delete();
      repeat (n) pay_q.push_back(8'($urandom));
      zlp = (pid[1:0] == 2'b11) && ($urandom_range(0, 4) == 0);
      if (zlp) pay_q.delete();
      drive_packet(pid, zlp, -1, 1, 0);
      build_expected(pid, zlp, -1);
      n_vec++;
      if (timed_out || obs_q.size() != exp_q.size()) begin
        n_err++; $display("FAIL rnd%0d_len: got %0d bytes timeout=%0d, want %0d", p, obs_q.size(), timed_out, exp_q.size());
      end else
        foreach (exp_q[i]) begin
          n_vec++;
          if (obs_q[i] !== exp_q[i]) begin
            n_err++; $display("FAIL rnd%0d_byte%0d: got %h, want %h", p, i, obs_q[i], exp_q[i]);
          end
        end
      n_vec++;
      if (obs_acc != exp_acc || obs_err != 0 || obs_done != 1 || !stable_ok) begin
        n_err++; $display("FAIL rnd%0d_pulses: got acc=%0d err=%0d done=%0d stable=%0d, want %0d 0 1 1",
                          p, obs_acc, obs_err, obs_done, stable_ok, exp_acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_zlp();
    test_payload4();
    test_underrun();
    test_start_busy();
    test_reset_midpacket();
    test_random_packets();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
